// File: rtl/timer_bank.sv
// timer_bank: NCH-channel prescaled compare timer on the cs/wen bus; optional capture via TIMER_BANK_CAPTURE_EN
module timer_bank #(
    parameter int WIDTH = 32,
    parameter int NCH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] din,
    input  logic             wen,
    input  logic             cs,
    output logic [WIDTH-1:0] dout,
    output logic             irq
`ifdef TIMER_BANK_CAPTURE_EN
    ,
    input  logic [NCH-1:0]   cap
`endif
);
    logic we, w1c, unused_addr;
    logic [2:0] csel, rsel;
    logic [NCH-1:0] mflag, cflag, ie_v;
    logic [WIDTH-1:0] rdata [NCH];
    logic [WIDTH-1:0] status;
    assign we = cs & wen;
    assign w1c = we & addr[6] & ~addr[0];
    assign csel = addr[5:3];
    assign rsel = addr[2:0];
    assign unused_addr = ^addr[WIDTH-1:7];
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic en, oneshot, ie, mf, cf;
        logic [WIDTH-1:0] pre, cmp, cnt, capv, precnt;
        logic sel, wr_ctrl, wr_pre, wr_cmp, wr_cnt, tick, match;
        assign sel = we & ~addr[6] & (csel == 3'(i));
        assign wr_ctrl = sel & (rsel == 3'd0);
        assign wr_pre = sel & (rsel == 3'd1);
        assign wr_cmp = sel & (rsel == 3'd2);
        assign wr_cnt = sel & (rsel == 3'd3);
        assign tick = en & (precnt == pre);
        // a CNT write swallows the tick, so it cannot match either
        assign match = tick & ~wr_cnt & (cnt == cmp);
        always_ff @(posedge clk) begin
            if (reset) begin
                {en, oneshot, ie, mf} <= '0;
                {pre, cmp, cnt, precnt} <= '0;
            end else begin
                precnt <= (tick | wr_ctrl | wr_pre | ~en) ? '0 : precnt + WIDTH'(1);
                if (wr_ctrl) {ie, oneshot, en} <= din[2:0];
                else if (match & oneshot) en <= 1'b0;
                if (wr_pre) pre <= din;
                if (wr_cmp) cmp <= din;
                if (wr_cnt) cnt <= din;
                else if (tick) cnt <= match ? '0 : cnt + WIDTH'(1);
                mf <= match | (mf & ~(w1c & din[i]));
            end
        end
`ifdef TIMER_BANK_CAPTURE_EN
        logic [2:0] sync;
        logic rise;
        assign rise = sync[1] & ~sync[2];
        always_ff @(posedge clk) begin
            if (reset) begin
                sync <= '0;
                cf <= 1'b0;
                capv <= '0;
            end else begin
                sync <= {sync[1:0], cap[i]};
                if (rise) capv <= cnt;
                cf <= rise | (cf & ~(w1c & din[8+i]));
            end
        end
`else
        assign capv = '0;
        assign cf = 1'b0;
`endif
        assign mflag[i] = mf;
        assign cflag[i] = cf;
        assign ie_v[i] = ie;
        assign rdata[i] = rsel == 3'd0 ? WIDTH'({ie, oneshot, en}) :
                          rsel == 3'd1 ? pre :
                          rsel == 3'd2 ? cmp :
                          rsel == 3'd3 ? cnt :
                          rsel == 3'd4 ? capv : '0;
    end
    always_comb begin
        status = '0;
        status[NCH-1:0] = mflag;
        status[8+:NCH] = cflag;
    end
    always_comb begin
        dout = '0;
        if (addr[6]) dout = addr[0] ? WIDTH'({16'h7B01, 8'(NCH), 8'(WIDTH)}) : status;
        else for (int k = 0; k < NCH; k++) if (csel == 3'(k)) dout = rdata[k];
    end
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else irq <= |((mflag | cflag) & ie_v);
    end
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: scoreboard bench for timer_bank (NCH=4, WIDTH=32), capture test under TIMER_BANK_CAPTURE_EN
module tb_timer_bank;
    localparam logic [31:0] STATUS = 32'h40, ID = 32'h41;
    logic clk = 0, reset = 1, wen = 0, cs = 0;
    logic [31:0] addr = 0, din = 0, dout;
    logic irq;
    int cyc = 0, n_chk = 0, n_fail = 0;
    int t, c1, c2, c, p;
    logic [31:0] q[$];
`ifdef TIMER_BANK_CAPTURE_EN
    logic [3:0] cap = 0;
`endif
    timer_bank #(.WIDTH(32), .NCH(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .din(din), .wen(wen), .cs(cs),
        .dout(dout), .irq(irq)
`ifdef TIMER_BANK_CAPTURE_EN
        , .cap(cap)
`endif
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [31:0] ra(int ch, int r);
        return 32'(ch * 8 + r);
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] mask, input logic [31:0] exp);
        q.push_back(exp);
        addr = a;
        #1;
        chk(tag, dout & mask, q.pop_front());
    endtask
    task automatic chk_irq(input string tag, input logic exp);
        q.push_back(32'(exp));
        #1;
        chk(tag, 32'(irq), q.pop_front());
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        din = d;
        cs = 1;
        wen = 1;
        @(negedge clk);
        cs = 0;
        wen = 0;
    endtask
    task automatic wait_flag(input int b, input int budget, output int when);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            addr = STATUS;
            #1;
            if (dout[b]) break;
        end
        when = cyc;
    endtask
    initial begin
        repeat (2) @(negedge clk);
        reset = 0;
        wr(ra(0, 1), 5);
        wr(ra(0, 1), 0);
        wr(ra(0, 0), 7);
        wr(ra(1, 3), 9);
        wr(ra(0, 1), 5);
        chk_irq("irq_before_reset", 1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        rd("rst_ctrl0", ra(0, 0), '1, 0);
        rd("rst_pre0", ra(0, 1), '1, 0);
        rd("rst_cnt1", ra(1, 3), '1, 0);
        rd("rst_status", STATUS, '1, 0);
        rd("rst_id", ID, '1, 32'h7B01_0420);
        chk_irq("rst_irq", 0);
        wr(ra(0, 2), 4);
        wr(ra(0, 1), 2);
        wr(ra(0, 0), 1);
        t = cyc;
        wait_flag(0, 40, c1);
        q.push_back(15);
        chk("ch0_first_period", 32'(c1 - t), q.pop_front());
        wr(STATUS, 1);
        rd("ch0_w1c", STATUS, 1, 0);
        wait_flag(0, 40, c2);
        q.push_back(15);
        chk("ch0_second_period", 32'(c2 - c1), q.pop_front());
        wr(ra(0, 0), 0);
        wr(ra(1, 2), 3);
        wr(ra(1, 0), 3);
        t = cyc;
        wait_flag(1, 20, c);
        q.push_back(4);
        chk("ch1_oneshot_ticks", 32'(c - t), q.pop_front());
        rd("ch1_en_cleared", ra(1, 0), '1, 2);
        rd("ch1_cnt_zero", ra(1, 3), '1, 0);
        repeat (3) @(negedge clk);
        rd("ch1_cnt_stays", ra(1, 3), '1, 0);
        wr(ra(2, 2), 200);
        wr(ra(2, 0), 1);
        wr(ra(2, 3), 50);
        rd("ch2_cnt_write_wins", ra(2, 3), '1, 50);
        wr(ra(2, 3), 199);
        wr(STATUS, 4);
        rd("ch2_set_beats_w1c", STATUS, 4, 4);
        wr(ra(2, 0), 0);
        chk_irq("irq_no_ie", 0);
        wr(ra(3, 0), 5);
        rd("ch3_flag_t0", STATUS, 8, 0);
        chk_irq("irq_t0", 0);
        @(negedge clk);
        rd("ch3_flag_t1", STATUS, 8, 8);
        chk_irq("irq_t1", 0);
        @(negedge clk);
        chk_irq("irq_t2", 1);
        wr(ra(3, 0), 4);
        wr(STATUS, 8);
        chk_irq("irq_after_w1c_edge", 1);
        @(negedge clk);
        chk_irq("irq_dropped", 0);
        rd("other_flags_kept", STATUS, 7, 7);
        wr(ra(5, 2), 123);
        rd("ch5_reads_zero", ra(5, 2), '1, 0);
        rd("ch1_not_aliased", ra(1, 2), '1, 3);
        rd("reg5_reads_zero", ra(0, 5), '1, 0);
`ifdef TIMER_BANK_CAPTURE_EN
        wr(ra(0, 2), 1000);
        wr(ra(0, 3), 0);
        wr(ra(0, 0), 1);
        t = cyc;
        repeat (3) @(negedge clk);
        p = cyc;
        cap[0] = 1;
        @(negedge clk);
        cap[0] = 0;
        repeat (2) @(negedge clk);
        rd("cap_value", ra(0, 4), '1, 32'(p + 2 - t));
        rd("cap_flag", STATUS, 32'h100, 32'h100);
`else
        rd("cap_reads_zero", ra(0, 4), '1, 0);
`endif
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
